// File: rtl/scaler_pkg.sv
// Shared definitions for the FS01 binary scaler and its strobe supervisor.
package scaler_pkg;

  localparam int SCALER_NSTAGES_DEF = 16;
  localparam int SCALER_WDOG_DEF    = 64;

  // The strobe the supervisor expects to see next.
  typedef enum logic {
    PH_A = 1'b0,
    PH_B = 1'b1
  } phase_t;

endpackage : scaler_pkg

// File: rtl/scaler_supervisor.sv
// Supervises the F01A/F01B strobe stream. It raises a failure alarm when the
// strobes stop, and a sticky error when A/B strobes arrive out of order.
module scaler_supervisor
  import scaler_pkg::*;
#(
  parameter int WDOG_LIMIT = SCALER_WDOG_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic f01a,
  input  logic f01b,
  output logic scafal,
  output logic seqerr
);

  // The watchdog saturates at WDOG_LIMIT, and the legal limit never exceeds
  // 65535, so a fixed 16-bit counter is wide enough.
  localparam logic [15:0] LIMIT = 16'(WDOG_LIMIT);

  phase_t      ph;
  logic [15:0] w;
  logic        any_strobe;
  logic        order_bad;

  assign any_strobe = f01a | f01b;

  // Ordering faults: both strobes together, A while B is due, or B while A is due.
  assign order_bad = (f01a & f01b)
                   | (f01a & (ph == PH_B))
                   | (f01b & ~f01a & (ph == PH_A));

  // Watchdog counter and alarm. A strobe clears the alarm at its own closing
  // edge, so the alarm is low in the cycle that follows that strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    if (!rst_n) begin
      w      <= '0;
      scafal <= 1'b0;
    end else begin
      if (any_strobe) begin
        w <= '0;
      end else if (w != LIMIT) begin
        w <= w + 16'd1;
      end
      scafal <= ~any_strobe & (w == LIMIT);
    end
  end

  // Phase tracker with sticky error. After any strobe the expected phase is
  // the opposite of the strobe seen; B wins when both arrive together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph     <= PH_A;
      seqerr <= 1'b0;
    end else begin
      if (f01b) begin
        ph <= PH_A;
      end else if (f01a) begin
        ph <= PH_B;
      end
      if (order_bad) begin
        seqerr <= 1'b1;
      end
    end
  end

endmodule : scaler_supervisor

// File: rtl/scaler_chain.sv
// Binary scaler driven by the FS01 fall strobe (F01B). It provides the stage
// levels FS/FS_n and one-cycle rise/fall strobes FA/FB for every stage, plus
// strobe-stream supervision (SCAFAL, SEQERR).
module scaler_chain
  import scaler_pkg::*;
#(
  parameter int NSTAGES    = SCALER_NSTAGES_DEF,
  parameter int WDOG_LIMIT = SCALER_WDOG_DEF
) (
  input  logic               SIM_CLK,
  input  logic               SIM_RST,
  input  logic               F01A,
  input  logic               F01B,
  output logic [NSTAGES-1:0] FS,
  output logic [NSTAGES-1:0] FS_n,
  output logic [NSTAGES-1:0] FA,
  output logic [NSTAGES-1:0] FB,
  output logic               SCAFAL,
  output logic               SEQERR
);

  logic [NSTAGES-1:0] c;
  logic [NSTAGES-1:0] c_next;
  logic [NSTAGES-1:0] fa_q;
  logic [NSTAGES-1:0] fb_q;

  // Next count: advance by one on F01B, wrapping naturally at 2^NSTAGES.
  always_comb begin
    // NOTE: the default assignment first keeps this block free of latches.
    c_next = c;
    if (F01B) begin
      c_next = c + NSTAGES'(1);
    end
  end

  // Count register and edge strobes. The strobes come from old/new count, so
  // they are valid exactly when the new FS first appears and zero otherwise.
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      c    <= '0;
      fa_q <= '0;
      fb_q <= '0;
    end else begin
      c    <= c_next;
      fa_q <= ~c & c_next;
      fb_q <= c & ~c_next;
    end
  end

  assign FS   = c;
  assign FS_n = ~c;
  assign FA   = fa_q;
  assign FB   = fb_q;

  scaler_supervisor #(
    .WDOG_LIMIT(WDOG_LIMIT)
  ) u_supervisor (
    .clk   (SIM_CLK),
    .rst_n (SIM_RST),
    .f01a  (F01A),
    .f01b  (F01B),
    .scafal(SCAFAL),
    .seqerr(SEQERR)
  );

endmodule : scaler_chain

// File: tb/tb_scaler_chain.sv
// Directed bench for scaler_chain. A 10-stage instance keeps the wrap-around
// run short while exercising the same logic as the 16-stage default.
module tb_scaler_chain;

  localparam int N    = 10;
  localparam int WDOG = 64;
  localparam logic [N-1:0] ONES = '1;

  logic         SIM_CLK;
  logic         SIM_RST;
  logic         F01A;
  logic         F01B;
  logic [N-1:0] FS;
  logic [N-1:0] FS_n;
  logic [N-1:0] FA;
  logic [N-1:0] FB;
  logic         SCAFAL;
  logic         SEQERR;

  int tests  = 0;
  int failed = 0;

  scaler_chain #(
    .NSTAGES   (N),
    .WDOG_LIMIT(WDOG)
  ) dut (
    .SIM_CLK(SIM_CLK),
    .SIM_RST(SIM_RST),
    .F01A   (F01A),
    .F01B   (F01B),
    .FS     (FS),
    .FS_n   (FS_n),
    .FA     (FA),
    .FB     (FB),
    .SCAFAL (SCAFAL),
    .SEQERR (SEQERR)
  );

  initial SIM_CLK = 1'b0;
  always #5 SIM_CLK = ~SIM_CLK;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within its time budget");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given strobes; outputs are settled on return.
  task automatic cyc(input logic a, input logic b);
    F01A = a;
    F01B = b;
    @(posedge SIM_CLK);
    #1;
    F01A = 1'b0;
    F01B = 1'b0;
  endtask

  task automatic pairs(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  // Reset for one edge and release between edges.
  task automatic do_reset();
    SIM_RST = 1'b0;
    @(posedge SIM_CLK);
    #1;
    SIM_RST = 1'b1;
  endtask

  initial begin
    SIM_RST = 1'b0;
    F01A    = 1'b0;
    F01B    = 1'b0;
    #12;
    check("rst_fs",     32'(FS),     32'h0);
    check("rst_fs_n",   32'(FS_n),   32'(ONES));
    check("rst_fa",     32'(FA),     32'h0);
    check("rst_fb",     32'(FB),     32'h0);
    check("rst_scafal", 32'(SCAFAL), 32'h0);
    check("rst_seqerr", 32'(SEQERR), 32'h0);
    SIM_RST = 1'b1;

    // 1: four proper pairs -> FS=4, FA[2] pulses once on the fourth
    pairs(3);
    check("t1_fs3",  32'(FS), 32'h3);
    check("t1_fa3",  32'(FA), 32'h1);
    cyc(1'b1, 1'b0);
    check("t1_fa_on_a", 32'(FA), 32'h0);
    cyc(1'b0, 1'b1);
    check("t1_fs4",   32'(FS),   32'h4);
    check("t1_fs_n4", 32'(FS_n), 32'h3FB);
    check("t1_fa4",   32'(FA),   32'h4);
    check("t1_fb4",   32'(FB),   32'h3);
    cyc(1'b0, 1'b0);
    check("t1_fa_once", 32'(FA), 32'h0);
    check("t1_fb_once", 32'(FB), 32'h0);
    check("t1_seqerr",  32'(SEQERR), 32'h0);

    // 2: run up to all ones, then one more advance wraps to zero
    do_reset();
    pairs(1023);
    check("t2_fs_max",  32'(FS),     32'h3FF);
    check("t2_seqerr",  32'(SEQERR), 32'h0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    check("t2_fs_wrap", 32'(FS),   32'h0);
    check("t2_fb_wrap", 32'(FB),   32'h3FF);
    check("t2_fa_wrap", 32'(FA),   32'h0);
    cyc(1'b0, 1'b0);
    check("t2_fb_gone", 32'(FB),   32'h0);

    // 3: stop strobes; one idle cycle already elapsed above
    idle(63);
    check("t3_no_alarm_64", 32'(SCAFAL), 32'h0);
    idle(1);
    check("t3_alarm_65", 32'(SCAFAL), 32'h1);
    idle(10);
    check("t3_alarm_held", 32'(SCAFAL), 32'h1);
    cyc(1'b1, 1'b0);
    check("t3_alarm_clear", 32'(SCAFAL), 32'h0);
    check("t3_fs_same",     32'(FS),     32'h0);
    cyc(1'b0, 1'b1);
    check("t3_fs_after", 32'(FS),     32'h1);
    check("t3_seqerr",   32'(SEQERR), 32'h0);

    // 4: A, B, B -> error on the second B, both advances counted
    do_reset();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    check("t4_ok_first", 32'(SEQERR), 32'h0);
    cyc(1'b0, 1'b1);
    check("t4_err",    32'(SEQERR), 32'h1);
    check("t4_fs2",    32'(FS),     32'h2);
    pairs(10);
    check("t4_fs12",   32'(FS),     32'hC);
    check("t4_sticky", 32'(SEQERR), 32'h1);

    // 5: simultaneous strobes -> error, single advance
    do_reset();
    pairs(1);
    cyc(1'b1, 1'b1);
    check("t5_err", 32'(SEQERR), 32'h1);
    check("t5_fs",  32'(FS),     32'h2);
    check("t5_fa",  32'(FA),     32'h2);
    pairs(1);
    check("t5_fs_next", 32'(FS), 32'h3);

    // Extra ordering cases: B first after reset, and A twice
    do_reset();
    cyc(1'b0, 1'b1);
    check("b_first_err", 32'(SEQERR), 32'h1);
    do_reset();
    cyc(1'b1, 1'b0);
    check("a_once_ok", 32'(SEQERR), 32'h0);
    cyc(1'b1, 1'b0);
    check("a_twice_err", 32'(SEQERR), 32'h1);
    check("a_no_count",  32'(FS),     32'h0);

    // 6: asynchronous reset mid-count at FS=0x0A5 with SEQERR set
    do_reset();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    pairs(163);
    check("t6_fs_pre",  32'(FS),     32'h0A5);
    check("t6_fa_pre",  32'(FA),     32'h1);
    check("t6_err_pre", 32'(SEQERR), 32'h1);
    #2;
    SIM_RST = 1'b0;
    #1;
    check("t6_fs",     32'(FS),     32'h0);
    check("t6_fs_n",   32'(FS_n),   32'(ONES));
    check("t6_fa",     32'(FA),     32'h0);
    check("t6_fb",     32'(FB),     32'h0);
    check("t6_scafal", 32'(SCAFAL), 32'h0);
    check("t6_seqerr", 32'(SEQERR), 32'h0);
    #2;
    SIM_RST = 1'b1;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    check("t6_post_fs",  32'(FS),     32'h1);
    check("t6_post_err", 32'(SEQERR), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_scaler_chain
